// File: rtl/hms_display_driver.sv
// Seconds-of-day to HH:MM:SS seven-segment driver. Converts by iterative
// subtraction (one step per clock) and updates all six digits at once.
module hms_display_driver #(
    parameter int unsigned SEC_PER_DAY  = 86400,
    parameter int unsigned SEC_PER_HOUR = 3600,
    parameter int unsigned SEC_PER_MIN  = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [16:0] time_in,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic        busy,
    output logic        valid,
    output logic        done
);

    localparam logic [16:0] L_DAY  = 17'(SEC_PER_DAY);
    localparam logic [16:0] L_HOUR = 17'(SEC_PER_HOUR);
    localparam logic [16:0] L_MIN  = 17'(SEC_PER_MIN);
    localparam logic [6:0]  L_BLANK = 7'h7F;
    localparam logic [6:0]  L_DASH  = 7'h3F;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_HRS, S_MINS, S_SPLIT, S_ENC, S_UPDATE
    } state_t;

    state_t      r_state;
    logic [16:0] r_last;
    logic        r_force;
    logic [16:0] r_rem;
    logic [4:0]  r_h;
    logic [5:0]  r_m;
    logic [5:0]  r_s;
    logic [1:0]  r_sel;
    logic [5:0]  r_val;
    logic [3:0]  r_tens;
    logic [3:0]  r_bcd [6];
    logic [6:0]  r_dig [6];
    logic [6:0]  r_hex [6];
    logic        r_busy;
    logic        r_valid;
    logic        r_done;
    logic [6:0]  w_seg [6];

    function automatic logic [6:0] seg_encode(input logic [3:0] d);
        case (d)
            4'd0:    seg_encode = 7'h40;
            4'd1:    seg_encode = 7'h79;
            4'd2:    seg_encode = 7'h24;
            4'd3:    seg_encode = 7'h30;
            4'd4:    seg_encode = 7'h19;
            4'd5:    seg_encode = 7'h12;
            4'd6:    seg_encode = 7'h02;
            4'd7:    seg_encode = 7'h78;
            4'd8:    seg_encode = 7'h00;
            4'd9:    seg_encode = 7'h10;
            default: seg_encode = L_DASH;
        endcase
    endfunction

    // Index 0 is the seconds-units digit, index 5 the hours-tens digit.
    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_enc
            assign w_seg[gi] = seg_encode(r_bcd[gi]);
        end
    endgenerate

    // State advances on the falling edge to stay in phase with the counter.
    always_ff @(negedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_last  <= '0;
            r_force <= 1'b1;
            r_rem   <= '0;
            r_h     <= '0;
            r_m     <= '0;
            r_s     <= '0;
            r_sel   <= '0;
            r_val   <= '0;
            r_tens  <= '0;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                r_bcd[i] <= '0;
                r_dig[i] <= L_BLANK;
                r_hex[i] <= L_BLANK;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (time_in != r_last || r_force) begin
                        r_rem   <= time_in;
                        r_last  <= time_in;
                        r_force <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (r_rem >= L_DAY) begin
                        for (int i = 0; i < 6; i++) r_dig[i] <= L_DASH;
                        r_state <= S_UPDATE;
                    end else begin
                        r_h     <= '0;
                        r_m     <= '0;
                        r_state <= S_HRS;
                    end
                end
                S_HRS: begin
                    if (r_rem >= L_HOUR) begin
                        r_rem <= r_rem - L_HOUR;
                        r_h   <= r_h + 5'd1;
                    end else begin
                        r_state <= S_MINS;
                    end
                end
                S_MINS: begin
                    if (r_rem >= L_MIN) begin
                        r_rem <= r_rem - L_MIN;
                        r_m   <= r_m + 6'd1;
                    end else begin
                        r_s     <= r_rem[5:0];
                        r_val   <= {1'b0, r_h};
                        r_tens  <= '0;
                        r_sel   <= '0;
                        r_state <= S_SPLIT;
                    end
                end
                S_SPLIT: begin
                    // Hours, minutes, then seconds share one tens/units splitter.
                    if (r_val >= 6'd10) begin
                        r_val  <= r_val - 6'd10;
                        r_tens <= r_tens + 4'd1;
                    end else begin
                        r_tens <= '0;
                        r_sel  <= r_sel + 2'd1;
                        case (r_sel)
                            2'd0: begin
                                r_bcd[5] <= r_tens;
                                r_bcd[4] <= r_val[3:0];
                                r_val    <= r_m;
                            end
                            2'd1: begin
                                r_bcd[3] <= r_tens;
                                r_bcd[2] <= r_val[3:0];
                                r_val    <= r_s;
                            end
                            default: begin
                                r_bcd[1] <= r_tens;
                                r_bcd[0] <= r_val[3:0];
                                r_state  <= S_ENC;
                            end
                        endcase
                    end
                end
                S_ENC: begin
                    for (int i = 0; i < 6; i++) r_dig[i] <= w_seg[i];
                    r_state <= S_UPDATE;
                end
                S_UPDATE: begin
                    for (int i = 0; i < 6; i++) r_hex[i] <= r_dig[i];
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign hex0  = r_hex[0];
    assign hex1  = r_hex[1];
    assign hex2  = r_hex[2];
    assign hex3  = r_hex[3];
    assign hex4  = r_hex[4];
    assign hex5  = r_hex[5];
    assign busy  = r_busy;
    assign valid = r_valid;
    assign done  = r_done;

endmodule

// File: tb/tb_hms_display_driver.sv
// Directed bench for hms_display_driver: drives and samples on the rising
// edge, half a period away from the design's falling-edge updates.
module tb_hms_display_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [16:0] time_in = '0;
    logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
    logic        busy, valid, done;
    logic [41:0] disp;

    int total = 0;
    int bad = 0;

    assign disp = {hex5, hex4, hex3, hex2, hex1, hex0};

    hms_display_driver dut (
        .clk    (clk),
        .rst    (rst),
        .time_in(time_in),
        .hex5   (hex5),
        .hex4   (hex4),
        .hex3   (hex3),
        .hex2   (hex2),
        .hex1   (hex1),
        .hex0   (hex0),
        .busy   (busy),
        .valid  (valid),
        .done   (done)
    );

    always #5 clk = ~clk;

    task automatic wait_done(output int cycles, output bit ok);
        ok = 1'b0;
        cycles = 0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            if (done === 1'b1) begin
                ok = 1'b1;
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b0;
        time_in = 17'd0;
        repeat (3) @(posedge clk);
        total++; if (disp !== {6{7'h7F}}) begin bad++; $display("FAIL reset_hex: got %h want %h", disp, {6{7'h7F}}); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b1;
        n = 0;
        for (int i = 0; i < 130; i++) begin
            @(posedge clk);
            if (done === 1'b1) n++;
        end
        total++; if (n != 1) begin bad++; $display("FAIL first_done_count: got %0d want 1", n); end
        total++; if (disp !== {6{7'h40}}) begin bad++; $display("FAIL first_hex: got %h want %h", disp, {6{7'h40}}); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL first_valid: got %b want 1", valid); end
        $display("reset: time_in=0 display=%h valid=%b done_pulses=%0d", disp, valid, n);
    endtask

    task automatic test_basic;
        int cyc;
        bit ok;
        time_in = 17'd45296;
        @(posedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_start: got %b want 1", busy); end
        wait_done(cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL basic_timeout: got no done want done"); end
        total++; if (disp !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
            bad++; $display("FAIL basic_hex: got %h want %h", disp, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_end: got %b want 0", busy); end
        @(posedge clk);
        total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse: got %b want 0", done); end
        $display("basic: time_in=45296 display=%h cycles=%0d", disp, cyc);
    endtask

    task automatic test_max_and_wrap;
        int cyc;
        bit ok;
        time_in = 17'd86399;
        wait_done(cyc, ok);
        total++; if (!ok || cyc > 110) begin bad++; $display("FAIL max_latency: got %0d want <=110 (done=%b)", cyc, ok); end
        total++; if (disp !== {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10}) begin
            bad++; $display("FAIL max_hex: got %h want %h", disp, {7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h10});
        end
        $display("max: time_in=86399 display=%h cycles=%0d", disp, cyc);
        time_in = 17'd0;
        wait_done(cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_timeout: got no done want done"); end
        total++; if (disp !== {6{7'h40}}) begin bad++; $display("FAIL wrap_hex: got %h want %h", disp, {6{7'h40}}); end
        $display("wrap: time_in=0 display=%h cycles=%0d", disp, cyc);
    endtask

    task automatic test_dash;
        int cyc;
        bit ok;
        time_in = 17'd86400;
        wait_done(cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL dash_timeout: got no done want done"); end
        total++; if (disp !== {6{7'h3F}}) begin bad++; $display("FAIL dash_86400: got %h want %h", disp, {6{7'h3F}}); end
        $display("dash: time_in=86400 display=%h cycles=%0d", disp, cyc);
        time_in = 17'd0;
        wait_done(cyc, ok);
        time_in = 17'd131071;
        wait_done(cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL dash_max_timeout: got no done want done"); end
        total++; if (disp !== {6{7'h3F}}) begin bad++; $display("FAIL dash_131071: got %h want %h", disp, {6{7'h3F}}); end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL dash_valid: got %b want 1", valid); end
        $display("dash: time_in=131071 display=%h cycles=%0d", disp, cyc);
    endtask

    task automatic test_mid_change;
        int cyc;
        bit ok;
        time_in = 17'd3661;
        @(posedge clk);
        repeat (3) @(posedge clk);
        time_in = 17'd7322;
        wait_done(cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_first_timeout: got no done want done"); end
        total++; if (disp !== {7'h40, 7'h79, 7'h40, 7'h79, 7'h40, 7'h79}) begin
            bad++; $display("FAIL mid_first_hex: got %h want %h", disp, {7'h40, 7'h79, 7'h40, 7'h79, 7'h40, 7'h79});
        end
        $display("mid: first done display=%h", disp);
        @(posedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_restart_busy: got %b want 1", busy); end
        wait_done(cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_second_timeout: got no done want done"); end
        total++; if (disp !== {7'h40, 7'h24, 7'h40, 7'h24, 7'h40, 7'h24}) begin
            bad++; $display("FAIL mid_second_hex: got %h want %h", disp, {7'h40, 7'h24, 7'h40, 7'h24, 7'h40, 7'h24});
        end
        $display("mid: second done display=%h", disp);
    endtask

    task automatic test_reset_mid;
        int cyc;
        bit ok;
        time_in = 17'd45296;
        repeat (20) @(posedge clk);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rstmid_busy_before: got %b want 1", busy); end
        rst = 1'b0;
        #1;
        total++; if (disp !== {6{7'h7F}}) begin bad++; $display("FAIL rstmid_hex: got %h want %h", disp, {6{7'h7F}}); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rstmid_valid: got %b want 0", valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        @(posedge clk);
        rst = 1'b1;
        wait_done(cyc, ok);
        total++; if (!ok) begin bad++; $display("FAIL rstmid_timeout: got no done want done"); end
        total++; if (disp !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
            bad++; $display("FAIL rstmid_hex_after: got %h want %h", disp, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
        end
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL rstmid_valid_after: got %b want 1", valid); end
        $display("reset_mid: time_in=45296 display=%h valid=%b", disp, valid);
    endtask

    initial begin
        test_reset;
        test_basic;
        test_max_and_wrap;
        test_dash;
        test_mid_change;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hms_display_driver.md
Name: hms_display_driver

Overview:
- Consumes the 17-bit seconds-of-day value produced by the clock counter block (0..86399) and converts it, sequentially, into hours/minutes/seconds BCD.
- Drives six active-low seven-segment digits (HH:MM:SS) for the board display.
- Conversion uses iterative subtraction, one step per clock, so no dividers are inferred.
- Outputs update atomically when a conversion completes.

Parameters:
- SEC_PER_DAY, 86400, first out-of-range input value; inputs >= this show dashes.
- SEC_PER_HOUR, 3600, hour subtraction step.
- SEC_PER_MIN, 60, minute subtraction step.

Ports:
- clk  input  1  system clock; all state updates on the falling edge of clk, matching the producer.
- rst  input  1  asynchronous active-low reset.
- time_in  input  17  seconds-of-day from the clock counter.
- hex5..hex0  output  7 each  segments gfedcba (bit0 = a), active-low. hex5/hex4 = hour tens/units, hex3/hex2 = minutes, hex1/hex0 = seconds.
- busy  output  1  high while a conversion is in progress.
- valid  output  1  low after reset; high from the first completed conversion onward.
- done  output  1  one-cycle pulse on the cycle the hex outputs update.

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE; hex* = 7'h7F (blank); busy=0, valid=0, done=0.
  - last_captured cleared; a force flag is set so the first post-reset cycle always starts a conversion.
- IDLE: if time_in != last_captured or force is set, latch time_in into rem and last_captured, clear force, busy=1, go to CHECK.
- CHECK:
  - If rem >= SEC_PER_DAY, load dash code 7'h3F into all six digit registers and go to UPDATE.
  - Otherwise clear h/m to 0 and go to HRS.
- HRS: if rem >= 3600, rem -= 3600 and h += 1; otherwise go to MINS. One subtraction per cycle; h max 23.
- MINS: if rem >= 60, rem -= 60 and m += 1; otherwise s = rem[5:0] and go to SPLIT.
- SPLIT: for each of h, m and s in turn, subtract 10 per cycle into a tens counter until the value is < 10. Remainder = units.
- ENC: map the six BCD nibbles to segment codes.
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex).
  - Nibble > 9 (unreachable) maps to 7'h3F.
- UPDATE:
  - All six hex outputs load simultaneously from the digit registers.
  - done=1 for this cycle; valid=1 and stays set.
  - busy=0; return to IDLE.
- Latency: IDLE to UPDATE <= 110 cycles (23 + 59 + 2 + 5 + 5 subtractions plus overhead). Far below 1 s, so no ticks are missed.
- Mid-conversion input change: time_in is ignored while busy. The mismatch against last_captured is seen in IDLE, so a new conversion starts the cycle after UPDATE. The final display always reflects the latest stable input.
- Hex outputs never show partial results; they change only in UPDATE.
- Width rules: rem is 17 bits, unsigned compares. h is 5 bits; m and s are 6 bits; BCD digits are 4 bits.
- Reset asserted mid-conversion aborts the conversion immediately: outputs blank, valid=0.
- Wrap 86399 -> 0 is handled as an ordinary value change.

Test Plan:
- Reset then release with time_in=0 -> within 110 cycles done pulses once; hex5..hex0 = 40,40,40,40,40,40; valid=1.
- time_in=45296 (12:34:56) -> hex5..hex0 = 79,24,30,19,12,02; busy high only during conversion.
- time_in=86399 -> 23:59:59 = 24,30,12,10,12,10; next time_in=0 -> all 40. Measured latency for 86399 must be <= 110 cycles.
- time_in=86400 and then 131071 -> all six digits = 3F; valid=1.
- Change time_in from 3661 to 7322 three cycles after 3661 is captured:
  - First done shows 01:01:01 (40,79,40,79,40,79).
  - A second conversion starts the cycle after UPDATE; the next done shows 02:02:02 (40,24,40,24,40,24).
- Assert rst mid-conversion -> outputs immediately 7F, valid=0, busy=0. After release, the same time_in is reconverted and displayed.
